funny_sweep_checker: RTL
========================

Name: funny_sweep_checker

Overview:
- Sequential stimulus-and-check stage wrapped around the 4-input "funny" function implementations (structural, dataflow, simplified).
- Upstream role: drives the shared input vector {a,b,c,d}.
- Downstream role: after a settle window, samples every implementation's f output, counts disagreements, records the first failing vector and captures the 16-entry truth table.
- Replaces the delay-based bench loop with a synthesizable, clocked sweep.

Parameters:
N_IN, 4, width of the input vector driven to the implementations (vector count = 2^N_IN)
N_IMPL, 3, number of implementation outputs compared
SETTLE, 1, cycles vec_out is held before sampling (must be >= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin sweep; sampled only in IDLE
vec_out  output  N_IN  current vector; bit N_IN-1 = a, bit 0 = d
f_in  input  N_IMPL  f outputs of the implementations; f_in[0] is the reference copy
busy  output  1  high from start acceptance until DONE exits
done  output  1  one-cycle pulse when the sweep completes
pass  output  1  1 when the finished sweep had zero mismatches; valid from done until next start
mismatch_cnt  output  N_IN+1  number of vectors where f_in bits disagreed
first_bad_vec  output  N_IN  first vector with a disagreement
first_bad_valid  output  1  first_bad_vec holds a real value
truth_table  output  2^N_IN  bit k = f_in[0] sampled for vector k

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, internal settle counter 0. Reset asserted mid-sweep aborts immediately to these values. No partial results are retained.
- State IDLE:
  - busy=0.
  - When start=1 at an edge: clear mismatch_cnt, first_bad_valid, first_bad_vec, truth_table and pass; set vec_out=0, settle counter=0; go to WAIT. This edge is "edge 0".
- State WAIT:
  - busy=1; vec_out is held stable.
  - The settle counter increments each cycle. After SETTLE cycles in WAIT, go to SAMPLE.
- State SAMPLE (one cycle):
  - Disagreement = f_in is neither all-0s nor all-1s.
  - On disagreement: mismatch_cnt+1. If first_bad_valid=0, set first_bad_vec=vec_out and first_bad_valid=1.
  - truth_table[vec_out] <= f_in[0].
  - If vec_out = 2^N_IN-1, go to DONE. Otherwise vec_out+1, counter=0, go to WAIT.
- Sample timing: vector k is sampled on edge (k+1)*(SETTLE+1).
- State DONE (one cycle):
  - done=1, busy=1.
  - pass = (final mismatch_cnt == 0), computed including the last sample's contribution.
  - Next state IDLE. vec_out wraps to 0 on exit.
- Completion timing: done is high in the cycle after edge 2^N_IN*(SETTLE+1). Defaults give edge 32.
- start while busy (WAIT/SAMPLE/DONE) is ignored. start held high continuously restarts a sweep on the first IDLE edge after DONE.
- Result hold: results (mismatch_cnt, first_bad_*, truth_table, pass) hold in IDLE until the next accepted start.
- Width rules:
  - mismatch_cnt cannot overflow (max 2^N_IN fits in N_IN+1 bits).
  - vec_out increments modulo 2^N_IN; overflow is never reached inside a sweep.
- f_in is treated as synchronous to clk (the implementations are combinational from vec_out). No synchronizers.

Decomposition:
- Shared package funny_pkg:
  - state enum {IDLE, WAIT, SAMPLE, DONE}
  - default N_IN=4
  - VEC_COUNT = 1<<N_IN
  - expected reference table constant FUNNY_TT = 16'hF5F5 (f = b | ~d)
- One natural sub-module: funny_agree, combinational N_IMPL-input all-equal detector producing the disagreement flag.
- Top module: FSM, counters and result registers.

Test Plan:
1. Three real funny implementations on f_in, SETTLE=1, pulse start → done at edge 32, pass=1, mismatch_cnt=0, first_bad_valid=0, truth_table=16'hF5F5.
2. f_in[2] tied to 1 → mismatch_cnt=4 (vectors 1,3,9,11), first_bad_vec=4'd1, first_bad_valid=1, pass=0, truth_table=16'hF5F5.
3. f_in[1] driven by the inverted reference → mismatch_cnt=16, first_bad_vec=0, pass=0.
4. rst_n low while vec_out=7 → all outputs 0 asynchronously, busy=0. Restart with start → clean pass as in test 1.
5. start pulsed at edges 5 and 20 during a sweep → ignored: exactly one done pulse, at edge 32. start held high → second sweep accepted on the IDLE edge after DONE.
6. SETTLE=3 → each vec_out value stable for 4 cycles, done at edge 64, results identical to test 1.

Source files
------------

// File: rtl/funny_sweep_checker_pkg.sv
// funny_pkg: shared state encoding and constants for the funny-function sweep checker.
package funny_pkg;
    localparam int N_IN_DEFAULT = 4;
    localparam int VEC_COUNT = 1 << N_IN_DEFAULT;
    localparam logic [15:0] FUNNY_TT = 16'hF5F5;
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
endpackage

// File: rtl/funny_sweep_checker_if.sv
// funny_sweep_checker_if: stimulus vector, implementation outputs and sweep results.
interface funny_sweep_checker_if #(parameter int N_IN = 4, parameter int N_IMPL = 3);
    logic                   start;
    logic [N_IN-1:0]        vec_out;
    logic [N_IMPL-1:0]      f_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          mismatch_cnt;
    logic [N_IN-1:0]        first_bad_vec;
    logic                   first_bad_valid;
    logic [(1<<N_IN)-1:0]   truth_table;
    modport master(input start, f_in, output vec_out, busy, done, pass, mismatch_cnt,
                   first_bad_vec, first_bad_valid, truth_table);
    modport slave(output start, f_in, input vec_out, busy, done, pass, mismatch_cnt,
                  first_bad_vec, first_bad_valid, truth_table);
endinterface

// File: rtl/funny_sweep_checker_agree.sv
// funny_agree: flags when the implementation outputs are not all equal.
module funny_agree #(parameter int N = 3) (
    input  logic [N-1:0] f,
    output logic         disagree
);
    assign disagree = !((&f) || !(|f));
endmodule

// File: rtl/funny_sweep_checker.sv
// funny_sweep_checker: clocked sweep of all input vectors, comparing every implementation
// against the reference and capturing the truth table.
module funny_sweep_checker
    import funny_pkg::*;
#(
    parameter int N_IN   = N_IN_DEFAULT,
    parameter int N_IMPL = 3,
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic rst_n,
    funny_sweep_checker_if.master bus
);
    localparam int CW = $clog2(SETTLE + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic disagree;
    funny_agree #(.N(N_IMPL)) u_agree (.f(bus.f_in), .disagree(disagree));
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE   ? (bus.start ? WAIT : IDLE) :
                   state == WAIT   ? (cnt == CW'(SETTLE - 1) ? SAMPLE : WAIT) :
                   state == SAMPLE ? (&bus.vec_out ? DONE : WAIT) : IDLE;
    end
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            bus.vec_out         <= '0;
            bus.pass            <= 1'b0;
            bus.mismatch_cnt    <= '0;
            bus.first_bad_vec   <= '0;
            bus.first_bad_valid <= 1'b0;
            bus.truth_table     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.start) begin
                    cnt                 <= '0;
                    bus.vec_out         <= '0;
                    bus.pass            <= 1'b0;
                    bus.mismatch_cnt    <= '0;
                    bus.first_bad_vec   <= '0;
                    bus.first_bad_valid <= 1'b0;
                    bus.truth_table     <= '0;
                end
                WAIT: cnt <= cnt + 1'b1;
                SAMPLE: begin
                    if (disagree) bus.mismatch_cnt <= bus.mismatch_cnt + 1'b1;
                    if (disagree && !bus.first_bad_valid) begin
                        bus.first_bad_vec   <= bus.vec_out;
                        bus.first_bad_valid <= 1'b1;
                    end
                    bus.truth_table[bus.vec_out] <= bus.f_in[0];
                    // pass must already include this last sample when DONE is entered
                    if (&bus.vec_out) bus.pass <= (bus.mismatch_cnt == '0) && !disagree;
                    else begin
                        bus.vec_out <= bus.vec_out + 1'b1;
                        cnt         <= '0;
                    end
                end
                default: bus.vec_out <= '0;
            endcase
        end
    end
endmodule
